// File: rtl/tb_mem_responder.sv
// Byte-addressed RAM model serving the tinyQV instruction-fetch and data ports.
// Data accesses take priority; an active fetch stream halts while data owns the memory.
module tb_mem_responder #(
  parameter int unsigned DEPTH_LOG2    = 16,
  parameter int unsigned INSTR_LATENCY = 4,
  parameter int unsigned DATA_LATENCY  = 4,
  parameter int unsigned CONT_LATENCY  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [23:1]           instr_addr,
  input  logic                  instr_fetch_restart,
  input  logic                  instr_fetch_stall,
  output logic                  instr_fetch_started,
  output logic                  instr_fetch_stopped,
  output logic [15:0]           instr_data_in,
  output logic                  instr_ready,
  input  logic [27:0]           data_addr,
  input  logic [1:0]            data_write_n,
  input  logic [1:0]            data_read_n,
  input  logic [31:0]           data_out,
  input  logic                  data_continue,
  output logic                  data_ready,
  output logic [31:0]           data_in,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [7:0]            load_data
);

  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = 16;

  typedef enum logic [1:0] {I_IDLE, I_WAIT, I_STREAM, I_HALT} istate_t;
  typedef enum logic [1:0] {D_IDLE, D_WAIT, D_DONE} dstate_t;

  logic [7:0] r_mem [DEPTH];

  istate_t       r_istate, w_istate_nxt;
  logic [CW-1:0] r_icnt, w_icnt_nxt;
  logic [AW-1:0] r_iaddr, w_iaddr_nxt;
  logic          r_started, w_started_nxt;
  logic          r_stopped, w_stopped_nxt;
  logic          r_iready, w_iready_nxt;
  logic [15:0]   r_idata, w_idata_nxt;

  dstate_t       r_dstate, w_dstate_nxt;
  logic [CW-1:0] r_dcnt, w_dcnt_nxt;
  logic [AW-1:0] r_daddr, w_daddr_nxt;
  logic [1:0]    r_dsize, w_dsize_nxt;
  logic          r_dwr, w_dwr_nxt;
  logic [31:0]   r_wdata, w_wdata_nxt;
  logic          r_dready, w_dready_nxt;
  logic [31:0]   r_din, w_din_nxt;

  logic          w_dreq, w_dwr, w_dbusy;
  logic [3:0]    w_mask, w_mem_we;
  logic [31:0]   w_rword, w_rmask;
  logic [15:0]   w_hword;
  logic          w_unused;

  assign w_dwr    = (data_write_n != 2'b11);
  assign w_dreq   = w_dwr || (data_read_n != 2'b11);
  // Data owns the memory from the request cycle until it is back in D_IDLE.
  assign w_dbusy  = (r_dstate != D_IDLE) || w_dreq;
  assign w_unused = ^{data_addr, instr_addr};

  always_comb begin
    case (r_dsize)
      2'b00:   w_mask = 4'b0001;
      2'b01:   w_mask = 4'b0011;
      2'b10:   w_mask = 4'b1111;
      default: w_mask = 4'b0000;
    endcase
  end

  // Each byte lane wraps independently around the memory.
  always_comb begin
    w_rword = '0;
    w_rmask = '0;
    for (int i = 0; i < 4; i++) begin
      w_rword[8*i +: 8] = r_mem[r_daddr + AW'(i)];
      w_rmask[8*i +: 8] = {8{w_mask[i]}};
    end
  end

  assign w_hword = {r_mem[r_iaddr + AW'(1)], r_mem[r_iaddr]};

  // Data FSM next state; access performed on the last wait cycle.
  always_comb begin
    w_dstate_nxt = r_dstate;
    w_dcnt_nxt   = r_dcnt;
    w_daddr_nxt  = r_daddr;
    w_dsize_nxt  = r_dsize;
    w_dwr_nxt    = r_dwr;
    w_wdata_nxt  = r_wdata;
    w_dready_nxt = 1'b0;
    w_din_nxt    = 32'h0;
    w_mem_we     = 4'b0000;
    case (r_dstate)
      D_IDLE: begin
        if (w_dreq) begin
          w_dstate_nxt = D_WAIT;
          w_daddr_nxt  = AW'(data_addr);
          w_dwr_nxt    = w_dwr;
          w_dsize_nxt  = w_dwr ? data_write_n : data_read_n;
          w_wdata_nxt  = data_out;
          w_dcnt_nxt   = data_continue ? CW'(CONT_LATENCY) : CW'(DATA_LATENCY);
        end
      end
      D_WAIT: begin
        if (r_dcnt <= CW'(1)) begin
          w_dstate_nxt = D_DONE;
          w_dcnt_nxt   = '0;
          w_dready_nxt = 1'b1;
          if (r_dwr) w_mem_we  = w_mask;
          else       w_din_nxt = w_rword & w_rmask;
        end else begin
          w_dcnt_nxt = r_dcnt - CW'(1);
        end
      end
      D_DONE:  w_dstate_nxt = D_IDLE;
      default: w_dstate_nxt = D_IDLE;
    endcase
  end

  // Instruction FSM next state; restart overrides everything.
  always_comb begin
    w_istate_nxt  = r_istate;
    w_icnt_nxt    = r_icnt;
    w_iaddr_nxt   = r_iaddr;
    w_started_nxt = 1'b0;
    w_stopped_nxt = 1'b0;
    w_iready_nxt  = 1'b0;
    w_idata_nxt   = 16'h0;
    if (instr_fetch_restart) begin
      w_istate_nxt  = I_WAIT;
      w_iaddr_nxt   = AW'({instr_addr, 1'b0});
      w_icnt_nxt    = CW'(INSTR_LATENCY);
      w_started_nxt = 1'b1;
    end else begin
      case (r_istate)
        I_WAIT, I_STREAM: begin
          if (w_dbusy) begin
            w_istate_nxt  = I_HALT;
            w_icnt_nxt    = '0;
            w_stopped_nxt = 1'b1;
          end else if ((r_istate == I_WAIT) && (r_icnt > CW'(1))) begin
            w_icnt_nxt = r_icnt - CW'(1);
          end else begin
            w_istate_nxt = I_STREAM;
            w_icnt_nxt   = '0;
            if (!instr_fetch_stall) begin
              w_iready_nxt = 1'b1;
              w_idata_nxt  = w_hword;
              w_iaddr_nxt  = r_iaddr + AW'(2);
            end
          end
        end
        I_HALT: begin
          if (!w_dbusy) begin
            w_istate_nxt  = I_WAIT;
            w_icnt_nxt    = CW'(INSTR_LATENCY);
            w_started_nxt = 1'b1;
          end
        end
        default: w_istate_nxt = r_istate;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_istate  <= I_IDLE;
      r_icnt    <= '0;
      r_iaddr   <= '0;
      r_started <= 1'b0;
      r_stopped <= 1'b0;
      r_iready  <= 1'b0;
      r_idata   <= '0;
      r_dstate  <= D_IDLE;
      r_dcnt    <= '0;
      r_daddr   <= '0;
      r_dsize   <= 2'b11;
      r_dwr     <= 1'b0;
      r_wdata   <= '0;
      r_dready  <= 1'b0;
      r_din     <= '0;
    end else begin
      r_istate  <= w_istate_nxt;
      r_icnt    <= w_icnt_nxt;
      r_iaddr   <= w_iaddr_nxt;
      r_started <= w_started_nxt;
      r_stopped <= w_stopped_nxt;
      r_iready  <= w_iready_nxt;
      r_idata   <= w_idata_nxt;
      r_dstate  <= w_dstate_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_daddr   <= w_daddr_nxt;
      r_dsize   <= w_dsize_nxt;
      r_dwr     <= w_dwr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_dready  <= w_dready_nxt;
      r_din     <= w_din_nxt;
    end
  end

  // Memory is never cleared; the backdoor load is last so it wins a byte collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_mem_we[i] && !rst) r_mem[r_daddr + AW'(i)] <= r_wdata[8*i +: 8];
    end
    if (load_en) r_mem[load_addr] <= load_data;
  end

  assign instr_fetch_started = r_started;
  assign instr_fetch_stopped = r_stopped;
  assign instr_data_in       = r_idata;
  assign instr_ready         = r_iready;
  assign data_ready          = r_dready;
  assign data_in             = r_din;

endmodule

// File: doc/tb_mem_responder.md
Name: tb_mem_responder

Overview:
Parametrised, synthesizable-style memory responder for CPU-level benches. It models a byte-addressed RAM behind the tinyQV instruction-fetch and data interfaces, with configurable access latency, sequential-continue latency and depth. It sits opposite tinyqv_cpu in a bench top and replaces ad-hoc cocotb memory handlers. It also arbitrates the single memory between instruction streaming and data accesses, so both paths see realistic stall behaviour.

Parameters:
DEPTH_LOG2, 16, log2 of memory size in bytes; all addresses wrap modulo 2^DEPTH_LOG2
INSTR_LATENCY, 4, cycles from fetch start to first instr_ready (minimum 1)
DATA_LATENCY, 4, cycles from data request to data_ready (minimum 1)
CONT_LATENCY, 1, cycles for a data access issued with data_continue=1 (minimum 1, at most DATA_LATENCY)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
instr_addr  input  23  halfword address [23:1] of fetch start
instr_fetch_restart  input  1  begin a new fetch stream at instr_addr
instr_fetch_stall  input  1  CPU cannot accept a halfword this cycle
instr_fetch_started  output  1  one-cycle pulse: stream has begun
instr_fetch_stopped  output  1  one-cycle pulse: stream has halted
instr_data_in  output  16  halfword to CPU
instr_ready  output  1  instr_data_in valid this cycle
data_addr  input  28  byte address
data_write_n  input  2  11 idle, 00 byte, 01 halfword, 10 word write
data_read_n  input  2  11 idle, 00 byte, 01 halfword, 10 word read
data_out  input  32  write data from CPU, little-endian, LSB-aligned
data_continue  input  1  request is sequential to previous access
data_ready  output  1  one-cycle pulse: access complete
data_in  output  32  read data, zero-extended, valid with data_ready
load_en  input  1  bench backdoor byte write, highest priority
load_addr  input  DEPTH_LOG2  backdoor byte address
load_data  input  8  backdoor byte

Behaviour:
- Reset: all outputs 0, both FSMs idle, latency counters 0, stream address 0. Memory contents are not cleared. A reset mid-access abandons it; no data_ready/instr_ready is issued for it.
- Instr FSM states: I_IDLE, I_WAIT, I_STREAM, I_HALT.
- instr_fetch_restart in any state: latch instr_addr, pulse instr_fetch_started next cycle, enter I_WAIT with counter=INSTR_LATENCY. Restart on the same cycle as an instr_ready discards the current stream.
- I_WAIT: decrement counter each cycle; at 0 go to I_STREAM.
- I_STREAM: each cycle with instr_fetch_stall=0, assert instr_ready with mem[addr+1:addr] and addr+=2 (wraps). With stall=1, instr_ready=0 and addr is held; no limit on stall length.
- Data FSM states: D_IDLE, D_WAIT, D_DONE. A request is any read_n or write_n value other than 11; both active at once makes write win.
- On request in D_IDLE: latch addr, size, wdata, and latency (CONT_LATENCY if data_continue, else DATA_LATENCY); enter D_WAIT.
- At counter 0: perform the access. data_ready pulses for exactly one cycle, with data_in = read value (writes drive data_in=0). Then D_DONE for one cycle, ignoring requests, then D_IDLE. Back-to-back throughput is therefore latency+2 cycles.
- Arbitration: data has priority. A data request while I_STREAM (or I_WAIT) completes any instr_ready of that cycle, then pulses instr_fetch_stopped next cycle and enters I_HALT.
- I_HALT: exit only when the data FSM returns to D_IDLE. Then pulse instr_fetch_started, reload INSTR_LATENCY, enter I_WAIT at the held address.
- Sub-word access: byte writes update 1 byte; halfword writes update 2; word writes update 4; little-endian throughout. Unaligned addresses are legal: bytes go to consecutive addresses, each wrapping independently. Upper data_addr bits above DEPTH_LOG2 are ignored.
- load_en: the byte is written the same cycle. If it hits the same byte as a data write in that cycle, load_en wins. Memory reads the same cycle return the old value.
- started/stopped/ready/data_ready are registered outputs; no combinational input-to-output path.

Test Plan:
- Preload 0x0000..0x0007 = 13 05 10 00 93 05 20 00, restart at instr_addr=0 -> started at cycle 1, instr_ready at cycle 1+4 with 0x0513, then 0x0010, 0x0593, 0x0020 on consecutive cycles.
- Same stream with stall held 3 cycles after the first halfword -> no instr_ready for 3 cycles; the next halfword is 0x0010 (none skipped or repeated).
- Word write 0xDEADBEEF to 0x100, then byte read 0x101 with continue=1 -> data_ready after 4 cycles, then after 1 cycle with data_in=0x000000BE.
- Data read issued mid-stream -> instr_fetch_stopped pulse, no instr_ready during access, then started pulse and resume at the next halfword after 4 cycles.
- Halfword write 0xA55A to address 2^DEPTH_LOG2-1 -> byte 0xFFFF=0x5A, byte 0x0000=0xA5.
- Assert rst in D_WAIT -> no data_ready, all outputs 0 next cycle, and a new request after reset completes normally.
